// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first: deserializes MOSI into words, serializes a one-entry buffered word onto MISO.
// Latency: every pin edge acts 3 clk cycles after capture (2 sync flops + 1 edge-detect stage).
// Backpressure: tx_load is honoured only while tx_ready=1; a word consumed from an empty buffer shifts zeros and pulses tx_underrun.
module spi_slave #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sck,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  input  logic [N-1:0] tx_data,
  input  logic         tx_load,
  output logic         tx_ready,
  output logic [N-1:0] rx_data,
  output logic         rx_valid,
  output logic         tx_underrun,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  // Synchronizer chains; index [1] is the synchronized copy, [2] the previous one for edge detect.
  logic [2:0] sck_sync;
  logic [2:0] cs_sync;
  logic [1:0] mosi_sync;

  logic sel_start;
  logic sel_end;
  logic sck_rise;
  logic sck_fall;
  logic mosi_bit;

  // FSM-decoded actions for this cycle.
  logic consume;
  logic do_rise;
  logic do_fall;
  logic word_done;
  logic clear;

  // Datapath state.
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  rx_shift;
  logic [N-1:0]  tx_shift;
  logic [N-1:0]  tx_buf;
  logic          tx_full;
  logic          load_ok;

  // Bring sck, cs_n and mosi into the clk domain; cs_n idles high so its chain resets to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= 3'b000;
      cs_sync   <= 3'b111;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      cs_sync   <= {cs_sync[1:0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign sel_start = cs_sync[2] & ~cs_sync[1];
  assign sel_end   = ~cs_sync[2] & cs_sync[1];
  assign sck_rise  = sck_sync[1] & ~sck_sync[2];
  assign sck_fall  = ~sck_sync[1] & sck_sync[2];
  // mosi has the same sync depth as sck, so this is the value present at the sck edge.
  assign mosi_bit  = mosi_sync[1];

  assign load_ok   = tx_load & ~tx_full;
  assign word_done = do_rise & (bit_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle actions; deselect wins over an sck edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    do_rise = 1'b0;
    do_fall = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_start) begin
          state_d = ACTIVE;
          consume = 1'b1;
        end
      end
      ACTIVE: begin
        if (sel_end) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else begin
          do_rise = sck_rise;
          do_fall = sck_fall;
          // The last rise of a word loads the next word so its MSB is ready before the next fall.
          if (sck_rise && (bit_cnt == LAST_BIT)) begin
            consume = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-entry transmit buffer: a consume empties it, a load into an empty buffer fills it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (consume) begin
      // A load coinciding with a consume on an empty buffer bypasses into tx_shift instead.
      tx_full <= 1'b0;
    end else if (load_ok) begin
      tx_buf  <= tx_data;
      tx_full <= 1'b1;
    end
  end

  // Transmit shifter: loaded on consume, shifted on sck fall except at a word boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_shift <= '0;
    end else if (clear) begin
      tx_shift <= '0;
    end else if (consume) begin
      if (tx_full) begin
        tx_shift <= tx_buf;
      end else if (tx_load) begin
        tx_shift <= tx_data;
      end else begin
        tx_shift <= '0;
      end
    end else if (do_fall && (bit_cnt != '0)) begin
      tx_shift <= {tx_shift[N-2:0], 1'b0};
    end
  end

  // Underrun pulse: consume found nothing buffered and nothing arriving to bypass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= consume & ~tx_full & ~tx_load;
    end
  end

  // Bit counter, wraps modulo N on each sck rise; cleared on deselect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (do_rise) begin
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
    end
  end

  // Receive shifter; a partial word is dropped on deselect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_shift <= '0;
    end else if (clear) begin
      rx_shift <= '0;
    end else if (do_rise) begin
      rx_shift <= {rx_shift[N-2:0], mosi_bit};
    end
  end

  // Completed-word register and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (word_done) begin
        rx_data <= {rx_shift[N-2:0], mosi_bit};
      end
    end
  end

  assign busy     = (state_q == ACTIVE);
  assign miso     = (state_q == ACTIVE) & tx_shift[N-1];
  assign tx_ready = ~tx_full;

endmodule
